// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register ids, status codes and
// the values that make up a nop bubble in a pipeline register.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_t;

    localparam logic [2:0]  BUBBLE_STAT  = SAOK;
    localparam logic [3:0]  BUBBLE_ICODE = INOP;
    localparam logic [3:0]  BUBBLE_IFUN  = 4'h0;
    localparam logic [3:0]  BUBBLE_REG   = RNONE;
    localparam logic [63:0] BUBBLE_VALC  = 64'h0;
    localparam logic [63:0] BUBBLE_VALP  = 64'h0;

endpackage

// File: rtl/fetch_align.sv
// Combinational instruction splitter: decodes the 10 fetched bytes at pc into
// fields, the fall-through PC, the fetch status and the predicted next PC.
module fetch_align
    import y86_pkg::*;
(
    input  logic [63:0] pc,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [2:0]  stat,
    output logic [63:0] predPC
);

    logic need_regids;
    logic need_valC;
    logic instr_valid;

    always_comb begin
        icode = imem_error ? INOP : imem_data[7:4];
        ifun  = imem_error ? 4'h0 : imem_data[3:0];

        need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
                                    IOPQ, IPUSHQ, IPOPQ};
        need_valC   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};

        rA = need_regids ? imem_data[15:12] : RNONE;
        rB = need_regids ? imem_data[11:8]  : RNONE;

        // The constant starts one byte later when a register byte is present.
        if (!need_valC)
            valC = '0;
        else if (need_regids)
            valC = imem_data[79:16];
        else
            valC = imem_data[71:8];

        valP = pc + 64'd1 + {63'd0, need_regids} + (need_valC ? 64'd8 : 64'd0);

        instr_valid = (icode <= IPOPQ);

        if (imem_error)
            stat = SADR;
        else if (!instr_valid)
            stat = SINS;
        else if (icode == IHALT)
            stat = SHLT;
        else
            stat = SAOK;

        predPC = (icode == IJXX || icode == ICALL) ? valC : valP;
    end

endmodule

// File: rtl/pipe_fetch.sv
// PIPE Y86-64 fetch stage: PC selection from M/W feedback, instruction
// decode via fetch_align, and the F (predicted PC) and D pipeline registers.
module pipe_fetch
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    output logic [63:0] F_predPC,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    logic [63:0] f_pc;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [2:0]  f_stat;
    logic [63:0] f_predPC;

    // A mispredicted branch outranks a returning ret.
    always_comb begin
        if (M_icode == IJXX && !M_Cnd)
            f_pc = M_valA;
        else if (W_icode == IRET)
            f_pc = W_valM;
        else
            f_pc = F_predPC;
    end

    assign imem_addr = f_pc;

    fetch_align u_align (
        .pc         (f_pc),
        .imem_data  (imem_data),
        .imem_error (imem_error),
        .icode      (f_icode),
        .ifun       (f_ifun),
        .rA         (f_rA),
        .rB         (f_rB),
        .valC       (f_valC),
        .valP       (f_valP),
        .stat       (f_stat),
        .predPC     (f_predPC)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            F_predPC <= RESET_PC;
        else if (!F_stall)
            F_predPC <= f_predPC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || (!D_stall && D_bubble)) begin
            D_stat  <= BUBBLE_STAT;
            D_icode <= BUBBLE_ICODE;
            D_ifun  <= BUBBLE_IFUN;
            D_rA    <= BUBBLE_REG;
            D_rB    <= BUBBLE_REG;
            D_valC  <= BUBBLE_VALC;
            D_valP  <= BUBBLE_VALP;
        end else if (!D_stall) begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
        end
    end

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed self-checking bench for pipe_fetch.
module tb_pipe_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;
    logic [63:0] F_predPC;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;

    int unsigned ntests = 0;
    int unsigned nfail  = 0;

    localparam logic [79:0] NOP    = 80'h10;
    localparam logic [79:0] IRMOVQ = 80'h0000_0000_0000_000A_F330; // irmovq $10,%rbx
    localparam logic [79:0] JXX    = 80'h0000_0000_0000_0001_0070; // jmp 0x100

    always #5 clk = ~clk;

    pipe_fetch #(.RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM), .imem_addr(imem_addr),
        .imem_data(imem_data), .imem_error(imem_error), .F_predPC(F_predPC),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA),
        .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [63:0] pc);
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        F_stall = 0; D_stall = 0; D_bubble = 0;
        M_icode = 0; M_Cnd = 0; M_valA = 0; W_icode = 0; W_valM = 0;
        imem_data = NOP; imem_error = 0;
        repeat (2) step();
        ntests++; if (F_predPC !== 64'h0) begin nfail++; $display("FAIL reset_predpc: got %h expected %h", F_predPC, 64'h0); end
        ntests++; if (D_icode !== 4'h1) begin nfail++; $display("FAIL reset_icode: got %h expected %h", D_icode, 4'h1); end
        ntests++; if (D_stat !== 3'd1) begin nfail++; $display("FAIL reset_stat: got %0d expected %0d", D_stat, 1); end
        ntests++; if (D_rA !== 4'hF) begin nfail++; $display("FAIL reset_rA: got %h expected %h", D_rA, 4'hF); end
        reset = 1'b0;
    endtask

    task automatic test_irmovq();
        imem_data = IRMOVQ;
        #1;
        ntests++; if (imem_addr !== 64'h0) begin nfail++; $display("FAIL irmovq_addr: got %h expected %h", imem_addr, 64'h0); end
        step();
        ntests++; if (D_icode !== 4'h3) begin nfail++; $display("FAIL irmovq_icode: got %h expected %h", D_icode, 4'h3); end
        ntests++; if (D_rA !== 4'hF || D_rB !== 4'h3) begin nfail++; $display("FAIL irmovq_regs: got %h/%h expected f/3", D_rA, D_rB); end
        ntests++; if (D_valC !== 64'd10) begin nfail++; $display("FAIL irmovq_valC: got %h expected %h", D_valC, 64'd10); end
        ntests++; if (D_valP !== 64'd10) begin nfail++; $display("FAIL irmovq_valP: got %h expected %h", D_valP, 64'd10); end
        ntests++; if (F_predPC !== 64'd10) begin nfail++; $display("FAIL irmovq_predpc: got %h expected %h", F_predPC, 64'd10); end
        ntests++; if (D_stat !== 3'd1) begin nfail++; $display("FAIL irmovq_stat: got %0d expected %0d", D_stat, 1); end
    endtask

    task automatic test_jxx();
        redirect(64'h20);
        imem_data = JXX;
        #1;
        ntests++; if (imem_addr !== 64'h20) begin nfail++; $display("FAIL jxx_addr: got %h expected %h", imem_addr, 64'h20); end
        step();
        ntests++; if (F_predPC !== 64'h100) begin nfail++; $display("FAIL jxx_predpc: got %h expected %h", F_predPC, 64'h100); end
        ntests++; if (D_valP !== 64'h29) begin nfail++; $display("FAIL jxx_valP: got %h expected %h", D_valP, 64'h29); end
        ntests++; if (D_valC !== 64'h100) begin nfail++; $display("FAIL jxx_valC: got %h expected %h", D_valC, 64'h100); end
        redirect(64'h29);
        #1;
        ntests++; if (imem_addr !== 64'h29) begin nfail++; $display("FAIL mispredict_addr: got %h expected %h", imem_addr, 64'h29); end
        M_Cnd = 1'b1;
        #1;
        ntests++; if (imem_addr !== 64'h100) begin nfail++; $display("FAIL taken_addr: got %h expected %h", imem_addr, 64'h100); end
        M_icode = 4'h0; M_Cnd = 1'b0;
    endtask

    task automatic test_ret();
        W_icode = 4'h9; W_valM = 64'h58;
        #1;
        ntests++; if (imem_addr !== 64'h58) begin nfail++; $display("FAIL ret_addr: got %h expected %h", imem_addr, 64'h58); end
        redirect(64'h40);
        #1;
        ntests++; if (imem_addr !== 64'h40) begin nfail++; $display("FAIL ret_vs_mispredict: got %h expected %h", imem_addr, 64'h40); end
        W_icode = 4'h0; M_icode = 4'h0;
    endtask

    task automatic test_status();
        redirect(64'h30);
        imem_data = 80'hC0;
        step();
        ntests++; if (D_stat !== 3'd4) begin nfail++; $display("FAIL sins_stat: got %0d expected %0d", D_stat, 4); end
        imem_error = 1'b1;
        step();
        ntests++; if (D_stat !== 3'd3) begin nfail++; $display("FAIL sadr_stat: got %0d expected %0d", D_stat, 3); end
        ntests++; if (D_icode !== 4'h1) begin nfail++; $display("FAIL sadr_icode: got %h expected %h", D_icode, 4'h1); end
        imem_error = 1'b0;
        imem_data = 80'h00;
        step();
        ntests++; if (D_stat !== 3'd2) begin nfail++; $display("FAIL shlt_stat: got %0d expected %0d", D_stat, 2); end
        ntests++; if (D_valP !== 64'h31) begin nfail++; $display("FAIL shlt_valP: got %h expected %h", D_valP, 64'h31); end
        M_icode = 4'h0;
    endtask

    task automatic test_stall_bubble();
        // D holds halt at 0x30, F_predPC = 0x31
        imem_data = IRMOVQ;
        F_stall = 1; D_stall = 1; D_bubble = 1;
        repeat (2) step();
        ntests++; if (D_icode !== 4'h0 || D_stat !== 3'd2) begin nfail++; $display("FAIL stall_hold_d: got icode %h stat %0d expected 0/2", D_icode, D_stat); end
        ntests++; if (D_valP !== 64'h31) begin nfail++; $display("FAIL stall_hold_valP: got %h expected %h", D_valP, 64'h31); end
        ntests++; if (F_predPC !== 64'h31) begin nfail++; $display("FAIL stall_hold_predpc: got %h expected %h", F_predPC, 64'h31); end
        F_stall = 0; D_stall = 0;
        step();
        ntests++; if (D_icode !== 4'h1 || D_valP !== 64'h0) begin nfail++; $display("FAIL bubble: got icode %h valP %h expected 1/0", D_icode, D_valP); end
        ntests++; if (D_stat !== 3'd1 || D_rA !== 4'hF) begin nfail++; $display("FAIL bubble_stat: got stat %0d rA %h expected 1/f", D_stat, D_rA); end
        ntests++; if (F_predPC !== 64'h3B) begin nfail++; $display("FAIL bubble_predpc: got %h expected %h", F_predPC, 64'h3B); end
        D_bubble = 0;
    endtask

    task automatic test_async_reset();
        step();
        #2 reset = 1'b1;
        #1;
        ntests++; if (F_predPC !== 64'h0) begin nfail++; $display("FAIL async_predpc: got %h expected %h", F_predPC, 64'h0); end
        ntests++; if (D_icode !== 4'h1 || D_valC !== 64'h0) begin nfail++; $display("FAIL async_d: got icode %h valC %h expected 1/0", D_icode, D_valC); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        redirect(64'hFFFF_FFFF_FFFF_FFFE);
        imem_data = NOP;
        step();
        ntests++; if (D_valP !== 64'hFFFF_FFFF_FFFF_FFFF) begin nfail++; $display("FAIL wrap_nop_valP: got %h expected %h", D_valP, 64'hFFFF_FFFF_FFFF_FFFF); end
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        imem_data = IRMOVQ;
        step();
        ntests++; if (D_valP !== 64'h6) begin nfail++; $display("FAIL wrap_irmovq_valP: got %h expected %h", D_valP, 64'h6); end
        ntests++; if (F_predPC !== 64'h6) begin nfail++; $display("FAIL wrap_predpc: got %h expected %h", F_predPC, 64'h6); end
        M_icode = 4'h0;
    endtask

    task automatic test_back_to_back();
        imem_data = NOP;
        #1;
        ntests++; if (imem_addr !== 64'h6) begin nfail++; $display("FAIL seq_addr: got %h expected %h", imem_addr, 64'h6); end
        step();
        step();
        ntests++; if (D_valP !== 64'h8 || D_icode !== 4'h1) begin nfail++; $display("FAIL seq_valP: got %h icode %h expected 8/1", D_valP, D_icode); end
        ntests++; if (F_predPC !== 64'h8) begin nfail++; $display("FAIL seq_predpc: got %h expected %h", F_predPC, 64'h8); end
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_jxx();
        test_ret();
        test_status();
        test_stall_bubble();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
